hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard controller for the RV32 core. It replaces the single-load-use check with a per-register latency scoreboard, so EX-stage units with different result latencies (ALU, load, multi-cycle multiply) stall dependent instructions in ID for exactly as long as needed. It also blocks write-after-write reordering and handles branch/jump redirects. It sits beside the ID/EX pipeline register and drives the IF/ID stall and flush controls.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_sb_entry.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types, latency classes and clamp helper for the hazard
//              scoreboard.                                   Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int HZ_NUM_REGS = 32;
  localparam int HZ_MAX_LAT  = 7;
  localparam int HZ_REG_AW   = $clog2(HZ_NUM_REGS);
  localparam int HZ_LAT_W    = $clog2(HZ_MAX_LAT + 1);

  typedef logic [HZ_REG_AW-1:0] reg_idx_t;
  typedef logic [HZ_LAT_W-1:0]  lat_t;

  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
  localparam lat_t LAT_MUL  = lat_t'(3);

  function automatic int lat_sat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sb_entry.sv
// ============================================================================
// hazard_sb_entry : one per-register latency counter (load, gated decrement).
//                                                            Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = HZ_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             is_zero_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // A new issue to this register replaces whatever is left of the old count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : per-register latency scoreboard driving IF/ID stall and
//                     flush. Optional macro HAZARD_PERF_EN adds perf counters.
//                                                            Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = HZ_NUM_REGS,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int MAX_LAT  = HZ_MAX_LAT,
  parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_AW-1:0]   rs1_id,
  input  logic [REG_AW-1:0]   rs2_id,
  input  logic                rs1_used_id,
  input  logic                rs2_used_id,
  input  logic                valid_id,
  input  logic [REG_AW-1:0]   rd_id,
  input  logic                rd_wen_id,
  input  logic [LAT_W-1:0]    lat_id,
  input  logic                redirect_ex,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_id,
  output logic                flush_ex,
`ifdef HAZARD_PERF_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [LAT_W-1:0]                lat_eff;
  logic [NUM_REGS-1:0][LAT_W-1:0]  cnt;
  logic [NUM_REGS-1:0]             nz;
  logic                            raw_hz;
  logic                            waw_hz;
  logic                            hazard;
  logic                            issue;

  assign lat_eff = LAT_W'(lat_sat(32'(lat_id), MAX_LAT));

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      logic zero_r;
      hazard_sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (issue & rd_wen_id & (rd_id == REG_AW'(r))),
        .load_val_i (lat_eff),
        .cnt_o      (cnt[r]),
        .is_zero_o  (zero_r)
      );
      assign nz[r] = ~zero_r;
    end
  endgenerate

  assign raw_hz = valid_id & ((rs1_used_id & nz[rs1_id]) | (rs2_used_id & nz[rs2_id]));
  // WAW only matters if the older write would land after the newer one.
  assign waw_hz = valid_id & rd_wen_id & (rd_id != '0) & (cnt[rd_id] > lat_eff);
  assign hazard = raw_hz | waw_hz;
  assign issue  = valid_id & ~hazard & ~redirect_ex;

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst_n) begin
      if (redirect_ex) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (hazard) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  assign busy_vec = rst_n ? nz : '0;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hazard && !redirect_ex && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (redirect_ex && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed checks of stall/flush control and counters.
//                                                            Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic        valid_id;
  logic [4:0]  rd_id;
  logic        rd_wen_id;
  logic [2:0]  lat_id;
  logic        redirect_ex;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        flush_ex;
  logic [31:0] busy_vec;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .valid_id    (valid_id),
    .rd_id       (rd_id),
    .rd_wen_id   (rd_wen_id),
    .lat_id      (lat_id),
    .redirect_ex (redirect_ex),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic [2:0] lat);
    valid_id    = v;
    rs1_id      = r1;
    rs1_used_id = u1;
    rs2_id      = r2;
    rs2_used_id = u2;
    rd_id       = rd;
    rd_wen_id   = wen;
    lat_id      = lat;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect_ex = 1'b1;
    idle();
    #2;
    chk("rst_flush_id", {31'd0, flush_id}, 32'd0);
    chk("rst_flush_ex", {31'd0, flush_ex}, 32'd0);
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    redirect_ex = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_vec, 32'd0);

    // Load then use: one stall cycle
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD);
    settle();
    chk("lu_prod_nostall", {31'd0, stall_id}, 32'd0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, LAT_ALU);
    settle();
    chk("lu_stall_if", {31'd0, stall_if}, 32'd1);
    chk("lu_stall_id", {31'd0, stall_id}, 32'd1);
    chk("lu_flush_ex", {31'd0, flush_ex}, 32'd1);
    chk("lu_flush_id", {31'd0, flush_id}, 32'd0);
    chk("lu_busy5", {31'd0, busy_vec[5]}, 32'd1);
    tick();
    settle();
    chk("lu_release", {31'd0, stall_id}, 32'd0);
    chk("lu_busy5_clr", {31'd0, busy_vec[5]}, 32'd0);
    tick();
    idle();

    // Multiply chain: three stall cycles
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, LAT_MUL);
    settle();
    chk("mul_prod_nostall", {31'd0, stall_id}, 32'd0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, LAT_ALU);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mul_stall", {31'd0, stall_id}, 32'd1);
      chk("mul_busy7", {31'd0, busy_vec[7]}, 32'd1);
      tick();
    end
    settle();
    chk("mul_release", {31'd0, stall_id}, 32'd0);
    chk("mul_busy7_clr", {31'd0, busy_vec[7]}, 32'd0);
    tick();
    idle();

    // WAW: older lat 3, newer lat 1 -> stall while cnt > 1
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_MUL);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LAT_LOAD);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("waw_stall", {31'd0, stall_id}, 32'd1);
      tick();
    end
    settle();
    chk("waw_release", {31'd0, stall_id}, 32'd0);
    tick();
    idle();
    settle();
    chk("waw_reload_busy9", {31'd0, busy_vec[9]}, 32'd1);
    tick();
    settle();
    chk("waw_busy9_clr", {31'd0, busy_vec[9]}, 32'd0);

    // x0 destination and unused source
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, LAT_MUL);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, LAT_ALU);
    settle();
    chk("x0_nostall", {31'd0, stall_id}, 32'd0);
    chk("x0_busy_vec", busy_vec, 32'd0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, LAT_LOAD);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 5'd11, 1'b1, LAT_ALU);
    settle();
    chk("unused_nostall", {31'd0, stall_id}, 32'd0);
    chk("unused_busy4", {31'd0, busy_vec[4]}, 32'd1);
    tick();
    idle();

    // Redirect during hazard
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_LOAD);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd2);
    redirect_ex = 1'b1;
    settle();
    chk("rd_flush_id", {31'd0, flush_id}, 32'd1);
    chk("rd_flush_ex", {31'd0, flush_ex}, 32'd1);
    chk("rd_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rd_stall_id", {31'd0, stall_id}, 32'd0);
    tick();
    redirect_ex = 1'b0;
    idle();
    settle();
    chk("rd_busy5_clr", {31'd0, busy_vec[5]}, 32'd0);
    chk("rd_dead_no_issue", {31'd0, busy_vec[12]}, 32'd0);
    tick();

    // Async reset mid multiply stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, LAT_MUL);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd13, 1'b1, LAT_ALU);
    settle();
    chk("ar_pre_stall", {31'd0, stall_id}, 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stall_if", {31'd0, stall_if}, 32'd0);
    chk("ar_stall_id", {31'd0, stall_id}, 32'd0);
    chk("ar_flush_ex", {31'd0, flush_ex}, 32'd0);
    chk("ar_busy", busy_vec, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("ar_post_busy", busy_vec, 32'd0);
    chk("ar_post_nostall", {31'd0, stall_id}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("ar_perf_stall", perf_stall_cnt, 32'd0);
    chk("ar_perf_flush", perf_flush_cnt, 32'd0);
`endif
    tick();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
